// File: rtl/acq_sequencer_pkg.sv
// acq_sequencer_pkg: shared constants, state encoding and mode helpers for
// the acquisition sequencer. Optional auto mode is built when ACQ_AUTO_MODE_EN
// is defined.
package acq_sequencer_pkg;

    // Register bus geometry and register map
    localparam int ACQ_REG_ADDR_W = 8;
    localparam int ACQ_REG_DATA_W = 16;
    localparam logic [ACQ_REG_ADDR_W-1:0] ACQ_ADDR_MODE    = 8'h10;
    localparam logic [ACQ_REG_ADDR_W-1:0] ACQ_ADDR_TIMEOUT = 8'h11;

    // Reset values: single mode, both channels enabled, 100 ticks
    localparam logic [ACQ_REG_DATA_W-1:0] ACQ_DEFAULT_MODE    = 16'h000C;
    localparam logic [ACQ_REG_DATA_W-1:0] ACQ_DEFAULT_TIMEOUT = 16'd100;

    // One timeout tick = 2^ACQ_PRESCALER_W clocks
    localparam int ACQ_PRESCALER_W = 10;

    // Mode field [1:0]; 2'b11 is reserved and decodes as single
    localparam logic [1:0] ACQ_MODE_SINGLE = 2'b00;
    localparam logic [1:0] ACQ_MODE_NORMAL = 2'b01;
    localparam logic [1:0] ACQ_MODE_AUTO   = 2'b10;

    typedef enum logic [2:0] {
        ACQ_ST_IDLE     = 3'd0,
        ACQ_ST_ARM      = 3'd1,
        ACQ_ST_WAIT_CAP = 3'd2,
        ACQ_ST_SEND_A   = 3'd3,
        ACQ_ST_SEND_B   = 3'd4,
        ACQ_ST_REARM    = 3'd5
    } acq_state_t;

    // Normal and auto both loop back to ARM after an upload
    function automatic logic acq_mode_rearms(input logic [1:0] mode);
        return (mode == ACQ_MODE_NORMAL) || (mode == ACQ_MODE_AUTO);
    endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// acq_sequencer_if: register bus, host requests, datapath status pulses and
// sequencer control pulses. master = host/datapath side, slave = sequencer.
interface acq_sequencer_if
    import acq_sequencer_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = ACQ_REG_ADDR_W,
    parameter int REG_DATA_WIDTH = ACQ_REG_DATA_W
);
    logic [REG_ADDR_WIDTH-1:0] register_addr;
    logic [REG_DATA_WIDTH-1:0] register_data;
    logic                      register_rdy;
    logic                      host_start;
    logic                      host_stop;
    logic                      capture_done;
    logic                      chA_done;
    logic                      chB_done;
    logic                      start_o;
    logic                      stop_o;
    logic                      force_trig_o;
    logic                      rqst_chA_o;
    logic                      rqst_chB_o;
    logic                      busy_o;
    logic [2:0]                state_o;

    modport master (
        output register_addr, register_data, register_rdy,
        output host_start, host_stop, capture_done, chA_done, chB_done,
        input  start_o, stop_o, force_trig_o, rqst_chA_o, rqst_chB_o,
        input  busy_o, state_o
    );

    modport slave (
        input  register_addr, register_data, register_rdy,
        input  host_start, host_stop, capture_done, chA_done, chB_done,
        output start_o, stop_o, force_trig_o, rqst_chA_o, rqst_chB_o,
        output busy_o, state_o
    );

endinterface

// File: rtl/acq_sequencer_timeout_timer.sv
// acq_timeout_timer: free-running prescaler feeding a saturating 16-bit tick
// counter. Emits a single registered expired pulse per clear, on the tick
// that brings the count up to the timeout value (timeout 0 fires on tick 1).
module acq_timeout_timer
    import acq_sequencer_pkg::*;
#(
    parameter int PRESCALER_WIDTH = ACQ_PRESCALER_W
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] timeout,
    output logic        expired
);
    logic [PRESCALER_WIDTH-1:0] presc;
    logic [15:0]                ticks;
    logic [15:0]                ticks_nx;
    logic                       fired;
    logic                       tick;
    logic                       hit;

    assign tick     = en && (presc == '1);
    assign ticks_nx = (ticks == 16'hFFFF) ? ticks : ticks + 16'd1;
    assign hit      = tick && !fired && (ticks_nx >= timeout);

    // Prescaler, tick count and one-shot latch; clear restarts the interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            ticks   <= '0;
            fired   <= 1'b0;
            expired <= 1'b0;
        end else if (clr) begin
            presc   <= '0;
            ticks   <= '0;
            fired   <= 1'b0;
            expired <= 1'b0;
        end else begin
            expired <= hit;
            if (en)   presc <= presc + 1'b1;
            if (tick) ticks <= ticks_nx;
            if (hit)  fired <= 1'b1;
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: turns one host start into arm -> wait capture -> upload A ->
// upload B, re-arming in normal/auto mode. Define ACQ_AUTO_MODE_EN to build
// the timeout/forced-trigger path; otherwise mode 10 runs as normal.
module acq_sequencer
    import acq_sequencer_pkg::*;
#(
    parameter int                        REG_ADDR_WIDTH      = ACQ_REG_ADDR_W,
    parameter int                        REG_DATA_WIDTH      = ACQ_REG_DATA_W,
    parameter logic [REG_ADDR_WIDTH-1:0] ADDR_ACQ_MODE       = ACQ_ADDR_MODE,
    parameter logic [REG_ADDR_WIDTH-1:0] ADDR_ACQ_TIMEOUT    = ACQ_ADDR_TIMEOUT,
    parameter logic [REG_DATA_WIDTH-1:0] DEFAULT_ACQ_MODE    = ACQ_DEFAULT_MODE,
    parameter logic [REG_DATA_WIDTH-1:0] DEFAULT_ACQ_TIMEOUT = ACQ_DEFAULT_TIMEOUT,
    parameter int                        PRESCALER_WIDTH     = ACQ_PRESCALER_W
)(
    input  logic           clk,
    input  logic           rst,
    acq_sequencer_if.slave bus
);
    acq_state_t state, state_nx;
    logic       first_q;     // first cycle in the current state

    logic [3:0] mode_reg;
    logic [1:0] act_mode;    // configuration captured at ARM
    logic       act_a_en;
    logic       act_b_en;
    logic       rearm;
    logic       auto_on;

    logic start_nx, stop_nx, rqa_nx, rqb_nx;
    logic start_q, stop_q, rqa_q, rqb_q, force_q;

    // Mode register write
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mode_reg <= DEFAULT_ACQ_MODE[3:0];
        else if (bus.register_rdy && bus.register_addr == ADDR_ACQ_MODE)
            mode_reg <= bus.register_data[3:0];
    end

    // Snapshot configuration at ARM so mid-cycle writes wait for the next arm
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_mode <= DEFAULT_ACQ_MODE[1:0];
            act_a_en <= DEFAULT_ACQ_MODE[2];
            act_b_en <= DEFAULT_ACQ_MODE[3];
        end else if (state == ACQ_ST_ARM) begin
            act_mode <= mode_reg[1:0];
            act_a_en <= mode_reg[2];
            act_b_en <= mode_reg[3];
        end
    end

    assign rearm = acq_mode_rearms(act_mode);

`ifdef ACQ_AUTO_MODE_EN
    logic [15:0] timeout_reg;
    logic [15:0] act_timeout;
    logic        tmr_clr;
    logic        tmr_en;

    // Timeout register write and ARM-time snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_reg <= DEFAULT_ACQ_TIMEOUT[15:0];
            act_timeout <= DEFAULT_ACQ_TIMEOUT[15:0];
        end else begin
            if (bus.register_rdy && bus.register_addr == ADDR_ACQ_TIMEOUT)
                timeout_reg <= bus.register_data[15:0];
            if (state == ACQ_ST_ARM)
                act_timeout <= timeout_reg;
        end
    end

    assign auto_on = (act_mode == ACQ_MODE_AUTO);
    assign tmr_clr = (state == ACQ_ST_ARM);
    // Timer only runs while waiting; a stop in the same cycle suppresses a force
    assign tmr_en  = (state == ACQ_ST_WAIT_CAP) && auto_on && !bus.host_stop;

    acq_timeout_timer #(
        .PRESCALER_WIDTH (PRESCALER_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .timeout (act_timeout),
        .expired (force_q)
    );
`else
    logic unused_cfg;

    assign auto_on    = 1'b0;
    assign force_q    = 1'b0;
    assign unused_cfg = ^{bus.register_data[REG_DATA_WIDTH-1:4], DEFAULT_ACQ_TIMEOUT,
                          ADDR_ACQ_TIMEOUT, auto_on} ^ (PRESCALER_WIDTH > 0);
`endif

    // State register plus first-cycle flag used to fire upload requests on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACQ_ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state   <= state_nx;
            first_q <= (state_nx != state);
        end
    end

    // Next state and pulse requests; stop overrides everything outside IDLE
    always_comb begin
        state_nx = state;
        start_nx = 1'b0;
        stop_nx  = 1'b0;
        rqa_nx   = 1'b0;
        rqb_nx   = 1'b0;
        if (bus.host_stop && state != ACQ_ST_IDLE) begin
            stop_nx  = 1'b1;
            state_nx = ACQ_ST_IDLE;
        end else begin
            unique case (state)
                ACQ_ST_IDLE: begin
                    if (bus.host_start && !bus.host_stop) state_nx = ACQ_ST_ARM;
                end
                ACQ_ST_ARM: begin
                    start_nx = 1'b1;
                    state_nx = ACQ_ST_WAIT_CAP;
                end
                ACQ_ST_WAIT_CAP: begin
                    if (bus.capture_done) state_nx = ACQ_ST_SEND_A;
                end
                ACQ_ST_SEND_A: begin
                    if (!act_a_en)         state_nx = ACQ_ST_SEND_B;
                    else if (first_q)      rqa_nx   = 1'b1;
                    else if (bus.chA_done) state_nx = ACQ_ST_SEND_B;
                end
                ACQ_ST_SEND_B: begin
                    if (!act_b_en)         state_nx = ACQ_ST_REARM;
                    else if (first_q)      rqb_nx   = 1'b1;
                    else if (bus.chB_done) state_nx = ACQ_ST_REARM;
                end
                ACQ_ST_REARM: begin
                    state_nx = rearm ? ACQ_ST_ARM : ACQ_ST_IDLE;
                end
                default: state_nx = ACQ_ST_IDLE;
            endcase
        end
    end

    // Registered one-cycle output pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rqa_q   <= 1'b0;
            rqb_q   <= 1'b0;
        end else begin
            start_q <= start_nx;
            stop_q  <= stop_nx;
            rqa_q   <= rqa_nx;
            rqb_q   <= rqb_nx;
        end
    end

    assign bus.start_o      = start_q;
    assign bus.stop_o       = stop_q;
    assign bus.force_trig_o = force_q;
    assign bus.rqst_chA_o   = rqa_q;
    assign bus.rqst_chB_o   = rqb_q;
    assign bus.busy_o       = (state != ACQ_ST_IDLE);
    assign bus.state_o      = state;

endmodule
